// File: rtl/floating_div_param.sv
// Iterative restoring floating-point divider: c = a / b, one quotient bit per cycle.
// Define FDIV_ROUND_EN for round-to-nearest-even; otherwise results are truncated.
module floating_div_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic [EXP_W+MAN_W:0] c,
    output logic                 complete,
    output logic                 busy,
    output logic                 ov,
    output logic                 dz
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int N   = MAN_W + 3;
    localparam int CW  = $clog2(N);
    localparam int EW2 = EXP_W + 2;
    localparam logic [EW2-1:0] BIAS  = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW2-1:0] E_MAX = EW2'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
    typedef enum logic [1:0] {CLS_NORMAL, CLS_ZERO, CLS_INF, CLS_INF_DZ} cls_t;

    state_t state, state_next;
    cls_t   cls, cls_in;

    logic                  sign;
    logic signed [EW2-1:0] exp_base;
    logic [MAN_W+1:0]      rem, rem_sub, rem_next;
    logic [MAN_W:0]        divisor;
    logic [N-1:0]          quo;
    logic [CW-1:0]         cnt;
    logic                  ge;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, a_inf, b_zero, b_inf;

    logic                  norm_shift, guard, sticky;
    logic [MAN_W-1:0]      mant, mant_fin;
    logic signed [EW2-1:0] exp_fin;
    logic [W-1:0]          res, inf_pat;
    logic                  res_ov, res_dz;
`ifdef FDIV_ROUND_EN
    logic round_up, carry;
`else
    logic unused_round;
    assign unused_round = guard ^ sticky;
`endif

    assign ea     = a[W-2 -: EXP_W];
    assign eb     = b[W-2 -: EXP_W];
    assign ma     = a[MAN_W-1:0];
    assign mb     = b[MAN_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = &ea;
    assign b_inf  = &eb;

    // Special-case priority: zero divisor dominates, then zero/inf dividend, then inf divisor.
    always_comb begin
        cls_in = CLS_NORMAL;
        if (b_zero)
            cls_in = CLS_INF_DZ;
        else if (a_zero)
            cls_in = CLS_ZERO;
        else if (a_inf)
            cls_in = CLS_INF;
        else if (b_inf)
            cls_in = CLS_ZERO;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        complete   = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_next = DIV;
            end
            DIV: begin
                if (cnt == CW'(N - 1))
                    state_next = NORM;
            end
            NORM: state_next = DONE;
            DONE: begin
                complete   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rem_sub  = rem - {1'b0, divisor};
        ge       = (rem >= {1'b0, divisor});
        rem_next = ge ? (rem_sub << 1) : (rem << 1);
    end

    // Quotient lies in (0.5, 2): a clear integer bit means one extra shift.
    always_comb begin
        norm_shift = ~quo[N-1];
        if (quo[N-1]) begin
            mant   = quo[N-2:2];
            guard  = quo[1];
            sticky = quo[0] | (|rem);
        end else begin
            mant   = quo[N-3:1];
            guard  = quo[0];
            sticky = |rem;
        end
        exp_fin = exp_base - EW2'(norm_shift);
`ifdef FDIV_ROUND_EN
        round_up          = guard & (sticky | mant[0]);
        {carry, mant_fin} = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
        if (carry)
            exp_fin = exp_fin + EW2'(1);
`else
        mant_fin = mant;
`endif
    end

    always_comb begin
        inf_pat = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        res     = {sign, {(EXP_W + MAN_W){1'b0}}};
        res_ov  = 1'b0;
        res_dz  = 1'b0;
        case (cls)
            CLS_INF_DZ: begin
                res    = inf_pat;
                res_ov = 1'b1;
                res_dz = 1'b1;
            end
            CLS_INF: begin
                res    = inf_pat;
                res_ov = 1'b1;
            end
            CLS_ZERO: res = {sign, {(EXP_W + MAN_W){1'b0}}};
            default: begin
                if (!exp_fin[EW2-1] && (exp_fin >= E_MAX)) begin
                    res    = inf_pat;
                    res_ov = 1'b1;
                end else if (!exp_fin[EW2-1] && (exp_fin != '0)) begin
                    res = {sign, exp_fin[EXP_W-1:0], mant_fin};
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign     <= 1'b0;
            cls      <= CLS_NORMAL;
            exp_base <= '0;
            rem      <= '0;
            divisor  <= '0;
            quo      <= '0;
            cnt      <= '0;
            c        <= '0;
            ov       <= 1'b0;
            dz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign     <= a[W-1] ^ b[W-1];
                        cls      <= cls_in;
                        exp_base <= EW2'(ea) - EW2'(eb) + BIAS;
                        rem      <= {2'b01, ma};
                        divisor  <= {1'b1, mb};
                        quo      <= '0;
                        cnt      <= '0;
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= {quo[N-2:0], ge};
                    cnt <= cnt + CW'(1);
                end
                NORM: begin
                    c  <= res;
                    ov <= res_ov;
                    dz <= res_dz;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_floating_div_param.sv
// Self-checking bench for floating_div_param: directed table, random vs. arithmetic model, corner sequences.
module tb_floating_div_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, complete0, busy0, ov0, dz0;
    logic [31:0] a0, b0, c0;
    logic        start1, complete1, busy1, ov1, dz1;
    logic [15:0] a1, b1, c1;

    floating_div_param dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .c(c0),
        .complete(complete0), .busy(busy0), .ov(ov0), .dz(dz0)
    );

    floating_div_param #(.EXP_W(5), .MAN_W(10)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1),
        .complete(complete1), .busy(busy1), .ov(ov1), .dz(dz1)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        ov;
        logic        dz;
    } vec_t;

    vec_t tbl[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: exact integer division of the significands, then normalise/round/pack.
    task automatic model_div(input logic [63:0] a, input logic [63:0] b, input int ew, input int mw,
                             output logic [63:0] c, output logic ov, output logic dz);
        logic [63:0] emask, mmask, num, den, q, r, mant, inf_pat, zero_pat;
        int ea, eb, e, sh, lsb_pos;
        logic sgn;
`ifdef FDIV_ROUND_EN
        logic g, st;
`endif
        emask    = (64'd1 << ew) - 1;
        mmask    = (64'd1 << mw) - 1;
        ea       = int'((a >> mw) & emask);
        eb       = int'((b >> mw) & emask);
        sgn      = a[ew+mw] ^ b[ew+mw];
        zero_pat = 64'(sgn) << (ew + mw);
        inf_pat  = zero_pat | (emask << mw);
        c = zero_pat; ov = 1'b0; dz = 1'b0;
        if (eb == 0) begin
            c = inf_pat; ov = 1'b1; dz = 1'b1;
        end else if (ea == 0) begin
            c = zero_pat;
        end else if (ea == int'(emask)) begin
            c = inf_pat; ov = 1'b1;
        end else if (eb == int'(emask)) begin
            c = zero_pat;
        end else begin
            num = (64'd1 << mw) | (a & mmask);
            den = (64'd1 << mw) | (b & mmask);
            q   = (num << (mw + 2)) / den;
            r   = (num << (mw + 2)) % den;
            if ((q >> (mw + 2)) != 0) begin sh = 0; lsb_pos = 2; end
            else begin sh = 1; lsb_pos = 1; end
            mant = q >> lsb_pos;
            e    = ea - eb + ((1 << (ew - 1)) - 1) - sh;
`ifdef FDIV_ROUND_EN
            g  = ((q >> (lsb_pos - 1)) & 64'd1) != 0;
            st = ((q & ((64'd1 << (lsb_pos - 1)) - 1)) != 0) || (r != 0);
            if (g && (st || mant[0])) mant = mant + 1;
            if ((mant >> (mw + 1)) != 0) begin mant = mant >> 1; e = e + 1; end
`endif
            if (e >= int'(emask)) begin
                c = inf_pat; ov = 1'b1;
            end else if (e > 0) begin
                c = zero_pat | (64'(e) << mw) | (mant & mmask);
            end
        end
    endtask

    function automatic logic [31:0] rand_op(input int ew, input int mw, input bit mid);
        logic [63:0] v;
        int bias = (1 << (ew - 1)) - 1;
        int e;
        if (mid) e = int'($urandom_range(bias + bias / 2, bias - bias / 2));
        else     e = int'($urandom_range((1 << ew) - 1, 0));
        v = (64'($urandom_range(1, 0)) << (ew + mw)) | (64'(e) << mw)
            | (64'($urandom) & ((64'd1 << mw) - 1));
        return v[31:0];
    endfunction

    // Issues one operation, scrambles operands after acceptance, waits (bounded) for complete.
    task automatic apply_stimulus(input int unit, input logic [31:0] op_a, input logic [31:0] op_b,
                                  output logic [31:0] res, output logic res_ov, output logic res_dz,
                                  output int lat, output int busy_cnt, output logic after);
        @(negedge clk);
        if (unit == 0) begin a0 = op_a; b0 = op_b; start0 = 1'b1; end
        else begin a1 = op_a[15:0]; b1 = op_b[15:0]; start1 = 1'b1; end
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        a0 = $urandom; b0 = $urandom; a1 = 16'($urandom); b1 = 16'($urandom);
        lat = 1; busy_cnt = 0;
        while (lat <= 100) begin
            if (unit == 0 ? busy0 : busy1) busy_cnt++;
            if (unit == 0 ? complete0 : complete1) break;
            @(negedge clk);
            lat++;
        end
        res    = (unit == 0) ? c0 : {16'h0, c1};
        res_ov = (unit == 0) ? ov0 : ov1;
        res_dz = (unit == 0) ? dz0 : dz1;
        @(negedge clk);
        after = (unit == 0) ? complete0 : complete1;
    endtask

    task automatic run_check(input string tag, input int unit, input logic [31:0] op_a, input logic [31:0] op_b,
                             input logic [31:0] ec, input logic eov, input logic edz);
        logic [31:0] rc;
        logic rov, rdz, after;
        int lat, bcnt, exp_lat;
        exp_lat = (unit == 0) ? 28 : 15;
        apply_stimulus(unit, op_a, op_b, rc, rov, rdz, lat, bcnt, after);
        check_output({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_output({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
        check_output({tag, "_c"}, 64'(rc), 64'(ec));
        check_output({tag, "_ov"}, 64'(rov), 64'(eov));
        check_output({tag, "_dz"}, 64'(rdz), 64'(edz));
        check_output({tag, "_pulse"}, 64'(after), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    logic [63:0] mc;
    logic        mov, mdz;
    logic [31:0] ra, rb;
    logic [31:0] b2b_a[3], b2b_b[3];
    logic        prev_c;
    int          k, cyc, last, ncomp;

    initial begin
        tbl.push_back('{"div6_2",       32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0});
`ifdef FDIV_ROUND_EN
        tbl.push_back('{"one_third",    32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0});
`else
        tbl.push_back('{"one_third",    32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0});
`endif
        tbl.push_back('{"neg6_2",       32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0});
        tbl.push_back('{"one_by_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b1});
        tbl.push_back('{"overflow",     32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 1'b0});
        tbl.push_back('{"underflow",    32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b0});
        tbl.push_back('{"zero_by_zero", 32'h00000000, 32'h00000000, 32'h7F800000, 1'b1, 1'b1});
        tbl.push_back('{"negzero_by_1", 32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0});
        tbl.push_back('{"inf_by_2",     32'h7F800000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0});
        tbl.push_back('{"two_by_inf",   32'h40000000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0});
        tbl.push_back('{"neginf_negz",  32'hFF800000, 32'h80000000, 32'h7F800000, 1'b1, 1'b1});
        tbl.push_back('{"denorm_flush", 32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0});
        tbl.push_back('{"exp_zero",     32'h3F800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b0});
        tbl.push_back('{"max_exp",      32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0});
        tbl.push_back('{"min_normal",   32'h00800000, 32'h3F000000, 32'h01000000, 1'b0, 1'b0});
        tbl.push_back('{"pi_by_pi",     32'h40490FDB, 32'h40490FDB, 32'h3F800000, 1'b0, 1'b0});

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("reset_c", 64'(c0), 64'd0);
        check_output("reset_complete", 64'(complete0), 64'd0);
        check_output("reset_busy", 64'(busy0), 64'd0);
        check_output("reset_ov", 64'(ov0), 64'd0);
        check_output("reset_dz", 64'(dz0), 64'd0);
        check_output("reset_c_half", 64'(c1), 64'd0);

        for (int i = 0; i < tbl.size(); i++)
            run_check(tbl[i].name, 0, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].ov, tbl[i].dz);

        for (int i = 0; i < 40; i++) begin
            ra = rand_op(8, 23, i < 28);
            rb = rand_op(8, 23, (i < 28) || (i % 2 == 0));
            model_div(64'(ra), 64'(rb), 8, 23, mc, mov, mdz);
            run_check("rand32", 0, ra, rb, mc[31:0], mov, mdz);
        end

        run_check("half_3_1", 1, 32'h4200, 32'h3C00, 32'h4200, 1'b0, 1'b0);
        run_check("half_ovf", 1, 32'h7800, 32'h0400, 32'h7C00, 1'b1, 1'b0);
        run_check("half_dz",  1, 32'h3C00, 32'h0000, 32'h7C00, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            ra = rand_op(5, 10, i < 14);
            rb = rand_op(5, 10, i < 14);
            model_div(64'(ra), 64'(rb), 5, 10, mc, mov, mdz);
            run_check("rand16", 1, ra, rb, mc[31:0], mov, mdz);
        end

        // start held high: one result per MAN_W+6 cycles, operands scrambled while busy
        b2b_a[0] = 32'h40C00000; b2b_b[0] = 32'h40000000;
        b2b_a[1] = 32'h3F800000; b2b_b[1] = 32'h40400000;
        b2b_a[2] = 32'hC0C00000; b2b_b[2] = 32'h3FC00000;
        @(negedge clk);
        a0 = b2b_a[0]; b0 = b2b_b[0]; start0 = 1'b1;
        k = 0; cyc = 0; last = 0; prev_c = 1'b0;
        while (k < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (prev_c) check_output("b2b_pulse", 64'(complete0), 64'd0);
            prev_c = complete0;
            if (complete0) begin
                model_div(64'(b2b_a[k]), 64'(b2b_b[k]), 8, 23, mc, mov, mdz);
                check_output("b2b_c", 64'(c0), mc);
                check_output("b2b_interval", 64'(cyc - last), (k == 0) ? 64'd28 : 64'd29);
                last = cyc;
                k++;
                if (k < 3) begin a0 = b2b_a[k]; b0 = b2b_b[k]; end
            end else if (busy0) begin
                a0 = $urandom; b0 = $urandom;
            end
        end
        check_output("b2b_count", 64'(k), 64'd3);
        start0 = 1'b0;
        repeat (2) @(negedge clk);

        // reset 10 cycles into an operation aborts it without a complete pulse
        a0 = 32'h40C00000; b0 = 32'h40000000; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (9) @(negedge clk);
        check_output("abort_busy_before", 64'(busy0), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_output("abort_c", 64'(c0), 64'd0);
        check_output("abort_busy", 64'(busy0), 64'd0);
        check_output("abort_complete", 64'(complete0), 64'd0);
        check_output("abort_ov", 64'(ov0), 64'd0);
        check_output("abort_dz", 64'(dz0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ncomp = 0;
        repeat (40) begin
            @(negedge clk);
            if (complete0) ncomp++;
        end
        check_output("abort_no_complete", 64'(ncomp), 64'd0);
        model_div(64'h3F800000, 64'h40400000, 8, 23, mc, mov, mdz);
        run_check("after_abort", 0, 32'h3F800000, 32'h40400000, mc[31:0], mov, mdz);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/floating_div_param.md
# floating_div_param

Parametrised iterative floating-point divider computing c = a / b on IEEE-754-style operands of configurable exponent and mantissa width. Restoring division producing one quotient bit per cycle; start/complete handshake with fixed latency. Next-generation replacement for the fixed 32-bit divider in the arithmetic circuit set; default parameters give single precision with an identical port set plus `busy` and `dz`.

## Interface
- `EXP_W`, 8, exponent field width (≥ 3); bias = 2^(EXP_W-1) − 1
- `MAN_W`, 23, stored mantissa field width (≥ 2); total operand width W = 1 + EXP_W + MAN_W

- `clk` input 1 — single clock, all state on rising edge
- `rst` input 1 — asynchronous, active-high reset
- `start` input 1 — request; sampled only in IDLE
- `a` input W — dividend, latched on accepted start
- `b` input W — divisor, latched on accepted start
- `c` output W — quotient; holds last result until next `complete`
- `complete` output 1 — one-cycle pulse, `c`/`ov`/`dz` valid
- `busy` output 1 — high from the cycle after accepted start through the `complete` cycle
- `ov` output 1 — result overflowed or was infinite; valid with `complete`, held
- `dz` output 1 — divisor was zero; valid with `complete`, held

## Operation
- FSM states: IDLE → DIV → NORM → DONE → IDLE.
- IDLE: if `start`=1, latch a/b, classify operands, load remainder = 1.ma, divisor = 1.mb, iteration counter = 0 → DIV. Otherwise stay.
- DIV: exactly N = MAN_W+3 cycles; each cycle remainder ≥ divisor → subtract, shift in 1; else shift in 0; remainder shifted left. Afterwards → NORM.
- NORM (1 cycle): quotient in (0.5, 2). If MSB=0, shift left 1 and decrement exponent. Sticky = OR(remaining remainder). Round, then pack. → DONE.
- DONE (1 cycle): `complete`=1, outputs update → IDLE. A `start` high in DONE is ignored; it is accepted in the following IDLE cycle.
- Sign: sa XOR sb, all cases including zero and infinity.
- Exponent: signed EXP_W+2-bit arithmetic, e = ea − eb + bias (−1 if normalisation shift). Mantissa round carry-out → mantissa 0, e+1.
- Special cases (evaluated at latch, result forced in NORM; latency unchanged):
  - exponent field 0 → operand treated as zero (denormals flushed); exponent all-ones → infinity (NaN not distinguished).
  - b zero, a non-zero: c = ±inf, `ov`=1, `dz`=1.
  - a zero and b zero: c = ±inf, `ov`=1, `dz`=1.
  - a zero, b non-zero: c = ±0, flags 0.
  - a inf: c = ±inf, `ov`=1. b inf (a finite): c = ±0.
  - e ≥ 2^EXP_W − 1 after rounding: c = ±inf, `ov`=1.
  - e ≤ 0: c = ±0 (flush), `ov`=0.

## Timing
- Reset: state IDLE, `c`=0, `complete`=0, `busy`=0, `ov`=0, `dz`=0, datapath registers cleared.
- Start accepted at edge T0; `complete` high in cycle T0 + N + 2 = T0 + MAN_W + 5 (28 cycles for defaults, 15 for EXP_W=5/MAN_W=10).
- Back-to-back: minimum issue interval MAN_W + 6 cycles.
- `start` while busy: ignored, no effect on in-flight operation; a/b may change freely after the accepting edge.
- `rst` mid-operation: immediate abort to reset values; no `complete` pulse produced for the aborted operation.

## Configuration
- `FDIV_ROUND_EN` defined: round-to-nearest-even using guard bit and sticky bit.
- Undefined: truncation (round toward zero); guard/sticky ignored, no round-carry path; latency unchanged.

## Test plan
- Defaults, a=0x40C00000 (6.0), b=0x40000000 (2.0), start pulse → `complete` exactly 28 cycles later, c=0x40400000, ov=0, dz=0, `busy` high 28 cycles.
- a=0x3F800000, b=0x40400000 (1/3) → c=0x3EAAAAAB with `FDIV_ROUND_EN`, 0x3EAAAAAA without; a=0xC0C00000, b=0x40000000 → c=0xC0400000.
- a=0x3F800000, b=0x00000000 → c=0x7F800000, ov=1, dz=1; a=0x7F000000, b=0x00800000 → c=0x7F800000, ov=1, dz=0; a=0x00800000, b=0x7F000000 → c=0x00000000, ov=0.
- `start` held high continuously with new operands each result → one op per 29 cycles, `start` during busy ignored, each `complete` a single-cycle pulse.
- `rst` asserted 10 cycles into 6.0/2.0 → all outputs 0 asynchronously; after release, new 1/3 request completes in 28 cycles with correct value.
- EXP_W=5, MAN_W=10: a=0x4200 (3.0), b=0x3C00 (1.0) → c=0x4200 in 15 cycles; a=0x7800, b=0x0400 → c=0x7C00, ov=1.
